uart_rx: RTL and testbench

//   Serial receive path of the UART peripheral. Samples the asynchronous rx pin
//   at OVERSAMPLE x baud, using the sample_tick enable from the UART clock divider.

---
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_rx.sv | 117 +++++++++++
 tb/tb_uart_rx.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART: sample enable, serial line, queue-full
// flag in; assembled byte, event pulses, busy and FSM state out.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  // data_valid is a one-cycle push strobe into the RX queue with no ready
  // back-pressure; fifo_full is checked when the stop bit is sampled and
  // turns the push into an overrun pulse instead.
  logic                 sample_tick;
  logic                 rx;
  logic                 fifo_full;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 framing_error;
  logic                 overrun;
  logic                 busy;
  logic [2:0]           dbg_state;

  modport master (
    output sample_tick, rx, fifo_full,
    input  data_out, data_valid, framing_error, overrun, busy, dbg_state
  );

  modport slave (
    input  sample_tick, rx, fifo_full,
    output data_out, data_valid, framing_error, overrun, busy, dbg_state
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver: synchronises rx, checks the start bit at
// mid-bit, shifts data LSB first, checks the stop bit and pushes good bytes.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t               state, state_next;
  logic                 rx_meta, rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, ferr_q, ovr_q;
  logic                 sample_bit, stop_tick;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else if (bus.sample_tick) state <= state_next;
  end

  always_comb begin
    state_next = state;
    sample_bit = 1'b0;
    stop_tick  = 1'b0;
    if (bus.sample_tick) begin
      case (state)
        IDLE:  if (!rx_s) state_next = START;
        START: if (tick_cnt == HALF) state_next = rx_s ? IDLE : DATA;
        DATA: begin
          if (tick_cnt == LAST) begin
            sample_bit = 1'b1;
            if (bit_cnt == LAST_BIT) state_next = STOP;
          end
        end
        STOP: begin
          if (tick_cnt == LAST) begin
            stop_tick  = 1'b1;
            state_next = rx_s ? IDLE : BRK;
          end
        end
        BRK:   if (rx_s) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Synchroniser runs every clk; everything else advances only on ticks,
  // except the event pulses which always drop after one clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      if (bus.sample_tick) begin
        if (sample_bit) begin
          shift   <= {rx_s, shift[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + BW'(1);
        end
        if (state_next != state) begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
        end else if (tick_cnt == LAST) begin
          tick_cnt <= '0;
        end else begin
          tick_cnt <= tick_cnt + TW'(1);
        end
        if (stop_tick) begin
          if (!rx_s) begin
            ferr_q <= 1'b1;
          end else if (bus.fifo_full) begin
            ovr_q <= 1'b1;
          end else begin
            valid_q <= 1'b1;
            data_q  <= shift;
          end
        end
      end
    end
  end

  assign bus.data_out      = data_q;
  assign bus.data_valid    = valid_q;
  assign bus.framing_error = ferr_q;
  assign bus.overrun       = ovr_q;
  assign bus.busy          = (state != IDLE);
  assign bus.dbg_state     = state;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives serial frames tick by tick, scoreboards received
// bytes and checks framing, overrun, glitch, reset and back-to-back cases.
module tb_uart_rx;
  localparam int OS = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(DW)) bus();

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  int dv_cnt      = 0;
  int fe_cnt      = 0;
  int ov_cnt      = 0;
  int tick_period = 1;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_good = '0;
  logic [DW-1:0] got;

  initial begin : tick_gen
    int cnt;
    cnt = 0;
    bus.sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      cnt++;
      if (cnt >= tick_period) begin
        cnt = 0;
        bus.sample_tick = 1'b1;
      end else begin
        bus.sample_tick = 1'b0;
      end
    end
  end

  // Scoreboard: every data_valid pops one expected byte.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.data_valid) begin
        dv_cnt++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard: unexpected data_valid, data_out=%h, expected no byte", bus.data_out);
        end else begin
          got = exp_q.pop_front();
          if (bus.data_out !== got) begin
            miscompares++;
            $display("FAIL scoreboard: data_out=%h expected %h", bus.data_out, got);
          end
        end
      end
      if (bus.framing_error) fe_cnt++;
      if (bus.overrun) ov_cnt++;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!bus.sample_tick);
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    @(negedge clk);
    bus.rx = b;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop);
    send_bit(1'b0, OS);
    for (int i = 0; i < DW; i++) send_bit(d[i], OS);
    send_bit(stop, OS);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.rx = 1'b1;
    bus.fifo_full = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if ({bus.data_out, bus.data_valid, bus.framing_error, bus.overrun, bus.busy} !== '0
        || bus.dbg_state !== 3'd0) begin
      miscompares++;
      $display("FAIL reset: out=%h dv=%b fe=%b ov=%b busy=%b state=%0d expected all 0",
               bus.data_out, bus.data_valid, bus.framing_error, bus.overrun, bus.busy, bus.dbg_state);
    end
    @(negedge clk);
    reset = 1'b0;
    send_bit(1'b1, 8);
  endtask

  task automatic test_basic;
    int dv0, fe0, ov0;
    dv0 = dv_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    send_bit(1'b1, 8);
    #1;
    vectors++;
    if (dv_cnt != dv0 + 1 || fe_cnt != fe0 || ov_cnt != ov0) begin
      miscompares++;
      $display("FAIL basic_counts: dv=%0d fe=%0d ov=%0d expected 1 0 0", dv_cnt - dv0, fe_cnt - fe0, ov_cnt - ov0);
    end
    vectors++;
    if (bus.data_out !== 8'h55) begin
      miscompares++;
      $display("FAIL basic_hold: data_out=%h expected 55", bus.data_out);
    end
    last_good = 8'h55;
  endtask

  task automatic test_glitch;
    int dv0;
    dv0 = dv_cnt;
    send_bit(1'b0, 4);
    #1;
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_busy_high: busy=%b expected 1", bus.busy);
    end
    send_bit(1'b1, 8);
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.dbg_state !== 3'd0) begin
      miscompares++;
      $display("FAIL glitch_idle: busy=%b state=%0d expected 0 0", bus.busy, bus.dbg_state);
    end
    send_bit(1'b1, 2 * OS);
    #1;
    vectors++;
    if (dv_cnt != dv0) begin
      miscompares++;
      $display("FAIL glitch_no_data: dv pulses=%0d expected 0", dv_cnt - dv0);
    end
  endtask

  task automatic test_framing;
    int dv0, fe0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'hA3, 1'b0);
    send_bit(1'b0, 40);
    #1;
    vectors++;
    if (fe_cnt != fe0 + 1 || dv_cnt != dv0) begin
      miscompares++;
      $display("FAIL framing_pulse: fe=%0d dv=%0d expected 1 0", fe_cnt - fe0, dv_cnt - dv0);
    end
    vectors++;
    if (bus.busy !== 1'b1 || bus.dbg_state !== 3'd4) begin
      miscompares++;
      $display("FAIL framing_break: busy=%b state=%0d expected 1 4", bus.busy, bus.dbg_state);
    end
    send_bit(1'b1, OS);
    #1;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL framing_release: busy=%b expected 0", bus.busy);
    end
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    send_bit(1'b1, 8);
    #1;
    vectors++;
    if (dv_cnt != dv0 + 1 || fe_cnt != fe0 + 1) begin
      miscompares++;
      $display("FAIL framing_recover: dv=%0d fe=%0d expected 1 1", dv_cnt - dv0, fe_cnt - fe0);
    end
    last_good = 8'h0F;
  endtask

  task automatic test_overrun;
    int dv0, ov0;
    dv0 = dv_cnt; ov0 = ov_cnt;
    bus.fifo_full = 1'b1;
    send_frame(8'h3C, 1'b1);
    send_bit(1'b1, 8);
    #1;
    bus.fifo_full = 1'b0;
    vectors++;
    if (ov_cnt != ov0 + 1 || dv_cnt != dv0) begin
      miscompares++;
      $display("FAIL overrun_pulse: ov=%0d dv=%0d expected 1 0", ov_cnt - ov0, dv_cnt - dv0);
    end
    vectors++;
    if (bus.data_out !== last_good) begin
      miscompares++;
      $display("FAIL overrun_hold: data_out=%h expected %h", bus.data_out, last_good);
    end
  endtask

  task automatic test_reset_mid;
    int dv0;
    dv0 = dv_cnt;
    send_bit(1'b0, OS);
    for (int i = 0; i < 3; i++) send_bit(1'b0, OS);
    @(negedge clk);
    reset = 1'b1;
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.data_out, bus.data_valid, bus.framing_error, bus.overrun, bus.busy} !== '0
        || bus.dbg_state !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_mid: out=%h dv=%b fe=%b ov=%b busy=%b state=%0d expected all 0",
               bus.data_out, bus.data_valid, bus.framing_error, bus.overrun, bus.busy, bus.dbg_state);
    end
    @(negedge clk);
    reset = 1'b0;
    send_bit(1'b1, 20);
    exp_q.push_back(8'hC8);
    send_frame(8'hC8, 1'b1);
    send_bit(1'b1, 8);
    #1;
    vectors++;
    if (dv_cnt != dv0 + 1) begin
      miscompares++;
      $display("FAIL reset_mid_frame: dv=%0d expected 1", dv_cnt - dv0);
    end
    last_good = 8'hC8;
  endtask

  task automatic test_back_to_back;
    int dv0;
    dv0 = dv_cnt;
    tick_period = 3;
    send_bit(1'b1, 4);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_bit(1'b1, 8);
    #1;
    vectors++;
    if (dv_cnt != dv0 + 2) begin
      miscompares++;
      $display("FAIL back_to_back: dv=%0d expected 2", dv_cnt - dv0);
    end
    tick_period = 1;
    send_bit(1'b1, 4);
    last_good = 8'hFF;
  endtask

  task automatic test_random;
    int dv0;
    logic [DW-1:0] d;
    dv0 = dv_cnt;
    for (int i = 0; i < 5; i++) begin
      d = DW'($urandom_range(0, 255));
      exp_q.push_back(d);
      send_frame(d, 1'b1);
      if ($urandom_range(0, 1) == 1) send_bit(1'b1, $urandom_range(1, 20));
    end
    send_bit(1'b1, 8);
    #1;
    vectors++;
    if (dv_cnt != dv0 + 5) begin
      miscompares++;
      $display("FAIL random_frames: dv=%0d expected 5", dv_cnt - dv0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_random();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d bytes left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
